// File: rtl/zone_frame_ctrl.sv
// zone_frame_ctrl: frame sequencer and ping-pong zone buffer for zone gray statistics.
// Optional running checksum of accepted writes when ZONE_CHECKSUM_EN is defined.
`default_nettype none

module zone_frame_ctrl #(
  parameter int COLS  = 24,
  parameter int ROWS  = 15,
  parameter int ZONES = COLS * ROWS,
  parameter int GW    = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          vsync_in,
  output logic          new_frame,
  input  logic          upd_in,
  input  logic [8:0]    index_in,
  input  logic [GW-1:0] gray_in,
  input  logic          row_end_in,
  input  logic          rd_lock,
  input  logic          rd_req,
  input  logic [8:0]    rd_addr,
  output logic [GW-1:0] rd_data,
  output logic          rd_valid,
  output logic          bank_sel,
  output logic          frame_ready,
  output logic          err_incomplete,
  output logic          err_overrun,
  output logic          err_range
`ifdef ZONE_CHECKSUM_EN
  ,
  output logic [GW-1:0] checksum
`endif
);

  localparam int AW = $clog2(2 * ZONES);
  localparam int ZW = $clog2(ZONES + 1);
  localparam int RW = $clog2(ROWS + 1);
  localparam logic [8:0]    ZONES_IDX = 9'(ZONES);
  localparam logic [ZW-1:0] ZONES_CNT = ZW'(ZONES);
  localparam logic [RW-1:0] ROWS_CNT  = RW'(ROWS);
  localparam logic [AW-1:0] BANK_OFS  = AW'(ZONES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SWAP    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic          vs_s1, vs_s2, vs_d, vs_edge;
  logic          upd_d;
  logic [ZW-1:0] zone_cnt;
  logic [RW-1:0] row_cnt;

  logic          nf_nxt, fr_nxt, toggle, clr_cnt, set_inc, set_ovr, count_en;
  logic          upd_rise, idx_ok, wr_en, range_hit;
  logic [AW-1:0] wr_addr, rd_maddr;

  logic [GW-1:0] mem [0:2*ZONES-1];

  // Two-flop synchroniser, then a registered rising-edge flag.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      vs_s1   <= 1'b0;
      vs_s2   <= 1'b0;
      vs_d    <= 1'b0;
      vs_edge <= 1'b0;
      upd_d   <= 1'b0;
    end else begin
      vs_s1   <= vsync_in;
      vs_s2   <= vs_s1;
      vs_d    <= vs_s2;
      vs_edge <= vs_s2 & ~vs_d;
      upd_d   <= upd_in;
    end
  end

  assign upd_rise  = upd_in & ~upd_d;
  assign idx_ok    = (index_in < ZONES_IDX);
  assign wr_en     = count_en & upd_rise & idx_ok;
  assign range_hit = count_en & upd_rise & ~idx_ok;
  assign wr_addr   = AW'(index_in) + (bank_sel ? '0 : BANK_OFS);
  assign rd_maddr  = AW'(rd_addr) + (bank_sel ? BANK_OFS : '0);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    nf_nxt    = 1'b0;
    fr_nxt    = 1'b0;
    toggle    = 1'b0;
    clr_cnt   = 1'b0;
    set_inc   = 1'b0;
    set_ovr   = 1'b0;
    count_en  = 1'b0;
    case (state)
      IDLE: begin
        if (vs_edge) begin
          nf_nxt    = 1'b1;
          clr_cnt   = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        // A new frame start overrides any row_end/upd activity in the same cycle.
        if (vs_edge) begin
          nf_nxt  = 1'b1;
          clr_cnt = 1'b1;
          set_inc = 1'b1;
        end else if (row_cnt == ROWS_CNT) begin
          if (zone_cnt == ZONES_CNT) begin
            state_nxt = SWAP;
          end else begin
            set_inc   = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          count_en = 1'b1;
        end
      end
      SWAP: begin
        if (vs_edge) begin
          nf_nxt    = 1'b1;
          clr_cnt   = 1'b1;
          set_ovr   = 1'b1;
          state_nxt = COLLECT;
        end else if (!rd_lock) begin
          toggle    = 1'b1;
          fr_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      new_frame      <= 1'b0;
      frame_ready    <= 1'b0;
      bank_sel       <= 1'b0;
      err_incomplete <= 1'b0;
      err_overrun    <= 1'b0;
      err_range      <= 1'b0;
      zone_cnt       <= '0;
      row_cnt        <= '0;
    end else begin
      new_frame   <= nf_nxt;
      frame_ready <= fr_nxt;
      if (toggle)    bank_sel       <= ~bank_sel;
      if (set_inc)   err_incomplete <= 1'b1;
      if (set_ovr)   err_overrun    <= 1'b1;
      if (range_hit) err_range      <= 1'b1;
      if (clr_cnt) begin
        zone_cnt <= '0;
        row_cnt  <= '0;
      end else if (count_en) begin
        if (wr_en)      zone_cnt <= zone_cnt + ZW'(1);
        if (row_end_in) row_cnt  <= row_cnt + RW'(1);
      end
    end
  end

  // Buffer has no reset; the write bank is always the one not on display.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= gray_in;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= (rd_addr < ZONES_IDX) ? mem[rd_maddr] : '0;
    end
  end

`ifdef ZONE_CHECKSUM_EN
  logic [GW-1:0] run_sum;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      run_sum  <= '0;
      checksum <= '0;
    end else begin
      if (clr_cnt)    run_sum <= '0;
      else if (wr_en) run_sum <= run_sum + gray_in;
      if (fr_nxt)     checksum <= run_sum;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_zone_frame_ctrl.sv
// tb_zone_frame_ctrl: directed self-checking bench for zone_frame_ctrl.
`default_nettype none

module tb_zone_frame_ctrl;

  localparam int GW = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          vsync_in = 1'b0;
  logic          new_frame;
  logic          upd_in = 1'b0;
  logic [8:0]    index_in = '0;
  logic [GW-1:0] gray_in = '0;
  logic          row_end_in = 1'b0;
  logic          rd_lock = 1'b0;
  logic          rd_req = 1'b0;
  logic [8:0]    rd_addr = '0;
  logic [GW-1:0] rd_data;
  logic          rd_valid, bank_sel, frame_ready;
  logic          err_incomplete, err_overrun, err_range;
`ifdef ZONE_CHECKSUM_EN
  logic [GW-1:0] checksum;
`endif

  zone_frame_ctrl dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .vsync_in(vsync_in), .new_frame(new_frame),
    .upd_in(upd_in), .index_in(index_in), .gray_in(gray_in), .row_end_in(row_end_in),
    .rd_lock(rd_lock), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .bank_sel(bank_sel), .frame_ready(frame_ready),
    .err_incomplete(err_incomplete), .err_overrun(err_overrun), .err_range(err_range)
`ifdef ZONE_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int vecs = 0;
  int miscompares = 0;
  int nf_cnt = 0;
  int fr_cnt = 0;

  always @(posedge sys_clk) begin
    if (new_frame)   nf_cnt++;
    if (frame_ready) fr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // vsync high for 3 samples; new_frame must appear exactly 3 edges after the first sample.
  task automatic vsync_pulse(input string tag);
    vsync_in = 1'b1;
    tick();
    tick();
    tick();
    chk({tag, "_nf_early"}, new_frame, 0);
    vsync_in = 1'b0;
    tick();
    chk({tag, "_nf"}, new_frame, 1);
  endtask

  task automatic write_zone(input int idx, input int gray, input int hold);
    index_in = idx[8:0];
    gray_in  = gray[GW-1:0];
    upd_in   = 1'b1;
    repeat (hold) tick();
    upd_in = 1'b0;
    tick();
  endtask

  task automatic row_end();
    row_end_in = 1'b1;
    tick();
    row_end_in = 1'b0;
  endtask

  function automatic int gval(input int mode, input int i);
    case (mode)
      0:       return i * 3;
      1:       return i + 7;
      2:       return i * 2;
      default: return 1;
    endcase
  endfunction

  task automatic run_frame(input int nz, input int mode);
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 24; c++) begin
        int i;
        i = r * 24 + c;
        if (i < nz) begin
          if (mode == 0 && i == 5) begin
            chk("hold_cnt_before", dut.zone_cnt, 5);
            write_zone(5, 16'hABCD, 11);
            chk("hold_cnt_after", dut.zone_cnt, 6);
          end else begin
            write_zone(i, gval(mode, i), 1);
          end
        end
      end
      row_end();
    end
  endtask

  task automatic do_read(input string tag, input int addr, input int exp);
    rd_addr = addr[8:0];
    rd_req  = 1'b1;
    tick();
    rd_req = 1'b0;
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_data"}, rd_data, exp);
  endtask

  initial begin
    int nf0, fr0;

    // Reset state
    tick();
    tick();
    chk("rst_new_frame", new_frame, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_bank_sel", bank_sel, 0);
    chk("rst_errs", {err_incomplete, err_overrun, err_range}, 0);
    chk("rst_rd", {rd_valid, rd_data}, 0);
    sys_rst = 1'b1;
    tick();

    // Full frame with rd_lock low
    vsync_pulse("f1");
    chk("f1_state", dut.state, 1);
    run_frame(360, 0);
    tick();
    chk("f1_fr_early", frame_ready, 0);
    tick();
    chk("f1_fr", frame_ready, 1);
    chk("f1_bank", bank_sel, 1);
    tick();
    chk("f1_fr_pulse", frame_ready, 0);
    chk("f1_nf_cnt", nf_cnt, 1);
    chk("f1_fr_cnt", fr_cnt, 1);
    do_read("rd100", 100, 300);
    do_read("rd5", 5, 16'hABCD);
    do_read("rd359", 359, 1077);
    do_read("rd_oor", 500, 0);
    chk("f1_errs", {err_incomplete, err_overrun, err_range}, 0);

    // Swap blocked by rd_lock for 50 cycles
    rd_lock = 1'b1;
    vsync_pulse("f2");
    run_frame(360, 1);
    fr0 = fr_cnt;
    repeat (50) tick();
    chk("blk_bank", bank_sel, 1);
    chk("blk_fr_cnt", fr_cnt, fr0);
    chk("blk_state", dut.state, 2);
    rd_lock = 1'b0;
    tick();
    chk("unblk_fr", frame_ready, 1);
    chk("unblk_bank", bank_sel, 0);
    do_read("rd_f2", 100, 107);

    // Overrun: vsync while a completed frame waits on rd_lock
    rd_lock = 1'b1;
    vsync_pulse("f3");
    run_frame(360, 2);
    repeat (10) tick();
    fr0 = fr_cnt;
    nf0 = nf_cnt;
    vsync_pulse("ovr");
    chk("ovr_flag", err_overrun, 1);
    chk("ovr_bank", bank_sel, 0);
    chk("ovr_state", dut.state, 1);
    chk("ovr_inc_clear", err_incomplete, 0);
    tick();
    chk("ovr_nf_cnt", nf_cnt, nf0 + 1);
    chk("ovr_fr_cnt", fr_cnt, fr0);
    rd_lock = 1'b0;

    // vsync mid-COLLECT restarts with err_incomplete
    write_zone(0, 9, 1);
    write_zone(1, 9, 1);
    write_zone(2, 9, 1);
    chk("mid_cnt", dut.zone_cnt, 3);
    vsync_pulse("mid");
    chk("mid_inc", err_incomplete, 1);
    chk("mid_cnt_clr", dut.zone_cnt, 0);
    chk("mid_state", dut.state, 1);

    // Out-of-range index
    chk("rng_before", err_range, 0);
    write_zone(400, 16'h1234, 1);
    chk("rng_flag", err_range, 1);
    chk("rng_cnt", dut.zone_cnt, 0);

    // Asynchronous reset mid-COLLECT
    write_zone(7, 5, 1);
    chk("pre_rst_cnt", dut.zone_cnt, 1);
    sys_rst = 1'b0;
    #2;
    chk("arst_errs", {err_incomplete, err_overrun, err_range}, 0);
    chk("arst_outs", {new_frame, frame_ready, bank_sel, rd_valid}, 0);
    chk("arst_state", dut.state, 0);
    chk("arst_cnt", dut.zone_cnt, 0);
    tick();
    tick();
    sys_rst = 1'b1;
    tick();

    // Short frame after reset: 359 zones
    fr0 = fr_cnt;
    vsync_pulse("sh");
    chk("sh_errs", {err_incomplete, err_overrun, err_range}, 0);
    run_frame(359, 1);
    tick();
    tick();
    chk("sh_inc", err_incomplete, 1);
    chk("sh_state", dut.state, 0);
    chk("sh_fr_cnt", fr_cnt, fr0);
    chk("sh_bank", bank_sel, 0);

`ifdef ZONE_CHECKSUM_EN
    vsync_pulse("cs");
    run_frame(360, 3);
    tick();
    tick();
    chk("cs_fr", frame_ready, 1);
    chk("cs_sum", checksum, 360);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/zone_frame_ctrl.md
Name: zone_frame_ctrl

Overview:
- Frame-level sequencer and buffer for the zone gray-statistics datapath.
- Detects video frame start and issues the 1-cycle new_frame pulse that restarts zone accumulation.
- Captures each zone result (index, gray) into a ping-pong zone buffer and counts completed zone rows.
- Swaps banks when a complete frame has been collected, arbitrating the swap against the downstream LED-board reader.

Parameters:
- COLS, 24, zones per zone row
- ROWS, 15, zone rows per frame
- ZONES, 360, total zones (COLS*ROWS); index range 0..ZONES-1
- GW, 16, gray value width

Ports:
- sys_clk, input, 1, system clock
- sys_rst, input, 1, asynchronous active-low reset
- vsync_in, input, 1, video frame sync, level; rising edge marks frame start
- new_frame, output, 1, 1-cycle pulse to the zone datapath; restarts accumulation
- upd_in, input, 1, zone result valid; held high for several cycles per zone
- index_in, input, 9, zone index paired with upd_in
- gray_in, input, GW, zone gray value paired with upd_in
- row_end_in, input, 1, 1-cycle pulse at the end of each zone row
- rd_lock, input, 1, high while the reader streams a frame; bank swap is forbidden while high
- rd_req, input, 1, read request
- rd_addr, input, 9, read zone address
- rd_data, output, GW, read data from the display bank
- rd_valid, output, 1, rd_data valid
- bank_sel, output, 1, current display (read) bank
- frame_ready, output, 1, 1-cycle pulse when a new frame becomes displayable
- err_incomplete, output, 1, sticky; frame aborted or short
- err_overrun, output, 1, sticky; completed frame dropped
- err_range, output, 1, sticky; index_in >= ZONES

Behaviour:
- Reset (sys_rst=0, asynchronous, any time including mid-frame) clears all of the following:
  - State returns to IDLE.
  - All outputs go to 0, including bank_sel (bank 0 displays, bank 1 is written).
  - zone_cnt, row_cnt and the upd_in edge register are cleared.
  - Buffer contents are not cleared.
- vsync_in goes through a 2-flop synchroniser followed by rising-edge detection. new_frame pulses for 1 cycle, 3 cycles after the first vsync_in high sample.
- Write bank is always ~bank_sel.
- States:
  - IDLE: on vsync edge, issue new_frame, clear zone_cnt and row_cnt, go to COLLECT.
  - COLLECT:
    - On each upd_in rising edge (upd_in=1 and previous upd_in=0), write gray_in to mem[~bank_sel][index_in] and increment zone_cnt.
    - Only the rising edge writes; the remaining high cycles are ignored.
    - If index_in >= ZONES, suppress the write, set err_range, and do not increment zone_cnt.
    - Each row_end_in pulse increments row_cnt.
    - When row_cnt reaches ROWS:
      - If zone_cnt == ZONES, go to SWAP.
      - Otherwise set err_incomplete and go to IDLE.
    - A vsync edge in COLLECT sets err_incomplete, issues new_frame and restarts COLLECT without a swap.
  - SWAP:
    - If rd_lock=0: toggle bank_sel, pulse frame_ready in the same cycle as the toggle, and go to IDLE.
    - If rd_lock=1: stay in SWAP.
    - A vsync edge while in SWAP: set err_overrun, drop the pending frame (no toggle), issue new_frame and go to COLLECT. The dropped frame's bank is overwritten.
- A row_end_in pulse and an upd_in edge in the same cycle are both counted.
- A vsync edge and a row_end_in pulse in the same cycle: vsync wins; row_end_in is discarded.
- Read port:
  - rd_req samples rd_addr; rd_data and rd_valid appear 1 cycle later from mem[bank_sel].
  - rd_addr >= ZONES returns 0 with rd_valid=1.
  - Reads are serviced in every state. A read issued in the toggle cycle uses the old bank_sel.
- Error flags clear only on reset.
- Storage: 2*ZONES words of GW bits. Single write port and single read port, usable in the same cycle. Write and read never target the same bank.

Optional Feature:
- Macro: ZONE_CHECKSUM_EN.
- When defined:
  - Adds output checksum [GW-1:0], reset 0.
  - A running modulo-2^GW sum of every accepted write is cleared on new_frame.
  - checksum is updated with the running sum in the frame_ready cycle.
- When undefined: the port and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Full frame, rd_lock=0: vsync edge, then 360 upd_in edges (index i, gray i*3) and 15 row_end_in pulses.
  - Required: one new_frame, frame_ready once, bank_sel 0->1.
  - Reading addr 100 returns 300 one cycle after rd_req.
- upd_in held high 11 cycles with index 5, gray 0xABCD.
  - Required: exactly one write, zone_cnt +1, and mem[5]=0xABCD after the swap.
- Swap blocked: complete frame while rd_lock=1 for 50 cycles.
  - Required: no toggle while rd_lock=1; frame_ready and toggle in the first cycle rd_lock=0.
  - A vsync edge during the block sets err_overrun, bank_sel is unchanged, and new_frame is issued.
- Short frame: 15 row_end_in pulses with only 359 zones.
  - Required: err_incomplete=1, no frame_ready, state IDLE.
  - Also: a vsync edge mid-COLLECT restarts with err_incomplete=1.
- Range and reset:
  - index_in=400 sets err_range with no zone_cnt change.
  - Asserting sys_rst=0 mid-COLLECT clears all outputs immediately, and the next vsync edge starts a clean frame.
- With ZONE_CHECKSUM_EN: a full frame of gray=1 gives checksum=360 at frame_ready.
